// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multi-cycle sequencer and the shared
// instruction/data memory port. The sequencer is the master: it raises
// mem_req (qualified by mem_we and IorD) and the memory answers with
// mem_ready in the cycle it completes the request.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic IorD;
    logic mem_ready;

    modport master (
        output mem_req,
        output mem_we,
        output IorD,
        input  mem_ready
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  IorD,
        output mem_ready
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
// Multi-cycle sequencer for the RV32 subset core. Each instruction walks
// FETCH -> DECODE -> EXEC -> (MEM) -> (WB) over a single shared memory port.
// All strobes are decoded combinationally from the state register and the
// IR opcode field and are forced low while rst_n is asserted, so a reset
// drops an in-flight request immediately.
//
// Optional feature: define MULTICYCLE_PERF_CNT_EN to add the cycle_cnt and
// instret_cnt performance counters (CNT_W bits each). Without it the ports
// and counters do not exist.
//
// MEM_TIMEOUT bounds the wait for mem_ready; 0 disables the timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        Opcode,
    multicycle_ctrl_if.master mem,
    output logic              ir_write,
    output logic              pc_write,
    output logic              ALUSrc,
    output logic              MemtoReg,
    output logic              RegWrite,
    output logic              Branch,
    output logic              JalrSel,
    output logic [1:0]        ALUOp,
    output logic [1:0]        RWSel,
    output logic              halted,
    output logic [1:0]        fault,
    output logic [2:0]        state
`ifdef MULTICYCLE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  instret_cnt
`endif
);

    // ------------------------------------------------------------------
    // Encodings
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALTED = 3'd5
    } state_e;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0010111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    localparam logic [1:0] ALUOP_ADD  = 2'b00;
    localparam logic [1:0] ALUOP_BR   = 2'b01;
    localparam logic [1:0] ALUOP_FUNC = 2'b10;
    localparam logic [1:0] ALUOP_JL   = 2'b11;

    localparam logic [1:0] RWSEL_ALU = 2'b00;
    localparam logic [1:0] RWSEL_PC4 = 2'b01;
    localparam logic [1:0] RWSEL_LUI = 2'b10;

    // The wait counter only has to hold 0 .. MEM_TIMEOUT-1: the cycle in
    // which it would reach MEM_TIMEOUT is the cycle that raises the fault.
    localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
    localparam int WAIT_W     = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST =
        WAIT_W'((MEM_TIMEOUT > 0) ? (MEM_TIMEOUT - 1) : 0);

    // Reject nonsensical configurations at elaboration time.
    if ((MEM_TIMEOUT < 0) || (CNT_W < 1)) begin : g_param_check
        $error("multicycle_ctrl: MEM_TIMEOUT must be >= 0 and CNT_W >= 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e            state_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [1:0]        fault_r;

    // Opcode classification
    logic is_r_s;
    logic is_i_s;
    logic is_lw_s;
    logic is_sw_s;
    logic is_br_s;
    logic is_lui_s;
    logic is_jal_s;
    logic is_jalr_s;
    logic is_halt_s;
    logic is_legal_s;

    // Per-opcode ALU controls, as in the single-cycle decoder
    logic       exec_alu_src_s;
    logic [1:0] exec_alu_op_s;
    logic       exec_branch_s;
    logic       exec_jalr_s;

    // Decoded strobes before reset gating
    logic       mem_req_s;
    logic       mem_we_s;
    logic       iord_s;
    logic       ir_write_s;
    logic       pc_write_s;
    logic       alu_src_s;
    logic       mem_to_reg_s;
    logic       reg_write_s;
    logic       branch_s;
    logic       jalr_sel_s;
    logic [1:0] alu_op_s;
    logic [1:0] rw_sel_s;

    logic       timeout_hit_s;

    // Classify the IR opcode field into instruction groups.
    always_comb begin
        is_r_s    = 1'b0;
        is_i_s    = 1'b0;
        is_lw_s   = 1'b0;
        is_sw_s   = 1'b0;
        is_br_s   = 1'b0;
        is_lui_s  = 1'b0;
        is_jal_s  = 1'b0;
        is_jalr_s = 1'b0;
        is_halt_s = 1'b0;
        case (Opcode)
            OP_R:    is_r_s    = 1'b1;
            OP_I:    is_i_s    = 1'b1;
            OP_LW:   is_lw_s   = 1'b1;
            OP_SW:   is_sw_s   = 1'b1;
            OP_BR:   is_br_s   = 1'b1;
            OP_LUI:  is_lui_s  = 1'b1;
            OP_JAL:  is_jal_s  = 1'b1;
            OP_JALR: is_jalr_s = 1'b1;
            OP_HALT: is_halt_s = 1'b1;
            default: is_r_s    = 1'b0;
        endcase
        is_legal_s = is_r_s | is_i_s | is_lw_s | is_sw_s | is_br_s |
                     is_lui_s | is_jal_s | is_jalr_s | is_halt_s;
    end

    // ALU operand/operation select and target select for each opcode.
    always_comb begin
        exec_alu_src_s = 1'b0;
        exec_alu_op_s  = ALUOP_ADD;
        exec_branch_s  = 1'b0;
        exec_jalr_s    = 1'b0;
        case (Opcode)
            OP_R: begin
                exec_alu_op_s  = ALUOP_FUNC;
            end
            OP_I: begin
                exec_alu_src_s = 1'b1;
                exec_alu_op_s  = ALUOP_FUNC;
            end
            OP_LW, OP_SW: begin
                exec_alu_src_s = 1'b1;
                exec_alu_op_s  = ALUOP_ADD;
            end
            OP_BR: begin
                exec_alu_op_s  = ALUOP_BR;
                exec_branch_s  = 1'b1;
            end
            OP_LUI: begin
                exec_alu_src_s = 1'b1;
                exec_alu_op_s  = ALUOP_JL;
            end
            OP_JAL: begin
                exec_alu_op_s  = ALUOP_JL;
                exec_branch_s  = 1'b1;
            end
            OP_JALR: begin
                exec_alu_src_s = 1'b1;
                exec_alu_op_s  = ALUOP_ADD;
                exec_jalr_s    = 1'b1;
            end
            default: begin
                exec_alu_src_s = 1'b0;
                exec_alu_op_s  = ALUOP_ADD;
            end
        endcase
    end

    // Flag the wait cycle that would bring the counter up to MEM_TIMEOUT.
    always_comb begin
        if (TIMEOUT_EN) begin
            timeout_hit_s = (wait_cnt_r == WAIT_LAST);
        end else begin
            timeout_hit_s = 1'b0;
        end
    end

    // Sequencer: next state, memory wait counter and sticky fault code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            wait_cnt_r <= '0;
            fault_r    <= FAULT_NONE;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (mem.mem_ready) begin
                        wait_cnt_r <= '0;
                        state_r    <= ST_DECODE;
                    end else if (timeout_hit_s) begin
                        wait_cnt_r <= '0;
                        fault_r    <= FAULT_TIMEOUT;
                        state_r    <= ST_HALTED;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (is_halt_s) begin
                        state_r <= ST_HALTED;
                    end else if (!is_legal_s) begin
                        fault_r <= FAULT_ILLEGAL;
                        state_r <= ST_HALTED;
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (is_lw_s || is_sw_s) begin
                        state_r <= ST_MEM;
                    end else if (is_br_s) begin
                        state_r <= ST_FETCH;
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_MEM: begin
                    if (mem.mem_ready) begin
                        wait_cnt_r <= '0;
                        state_r    <= is_lw_s ? ST_WB : ST_FETCH;
                    end else if (timeout_hit_s) begin
                        wait_cnt_r <= '0;
                        fault_r    <= FAULT_TIMEOUT;
                        state_r    <= ST_HALTED;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + 1'b1;
                    end
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                end
                ST_HALTED: begin
                    state_r <= ST_HALTED;
                end
                default: begin
                    // Unused encodings are treated as a corrupted sequencer.
                    fault_r <= FAULT_ILLEGAL;
                    state_r <= ST_HALTED;
                end
            endcase
        end
    end

    // Decode the datapath strobes from the current state and opcode.
    always_comb begin
        mem_req_s    = 1'b0;
        mem_we_s     = 1'b0;
        iord_s       = 1'b0;
        ir_write_s   = 1'b0;
        pc_write_s   = 1'b0;
        alu_src_s    = 1'b0;
        mem_to_reg_s = 1'b0;
        reg_write_s  = 1'b0;
        branch_s     = 1'b0;
        jalr_sel_s   = 1'b0;
        alu_op_s     = ALUOP_ADD;
        rw_sel_s     = RWSEL_ALU;
        case (state_r)
            ST_FETCH: begin
                mem_req_s  = 1'b1;
                ir_write_s = mem.mem_ready;
            end
            ST_EXEC: begin
                alu_src_s  = exec_alu_src_s;
                alu_op_s   = exec_alu_op_s;
                branch_s   = exec_branch_s;
                jalr_sel_s = exec_jalr_s;
                pc_write_s = is_br_s;
            end
            ST_MEM: begin
                mem_req_s  = 1'b1;
                iord_s     = 1'b1;
                mem_we_s   = is_sw_s;
                alu_src_s  = exec_alu_src_s;
                alu_op_s   = exec_alu_op_s;
                // A store retires in the cycle its write completes.
                pc_write_s = is_sw_s & mem.mem_ready;
            end
            ST_WB: begin
                reg_write_s  = 1'b1;
                pc_write_s   = 1'b1;
                mem_to_reg_s = is_lw_s;
                alu_src_s    = exec_alu_src_s;
                alu_op_s     = exec_alu_op_s;
                // Keep the jump target select stable for the PC commit.
                branch_s     = is_jal_s;
                jalr_sel_s   = is_jalr_s;
                if (is_jal_s || is_jalr_s) begin
                    rw_sel_s = RWSEL_PC4;
                end else if (is_lui_s) begin
                    rw_sel_s = RWSEL_LUI;
                end else begin
                    rw_sel_s = RWSEL_ALU;
                end
            end
            default: begin
                mem_req_s = 1'b0;
            end
        endcase
    end

    // Hold every strobe low for as long as reset is asserted.
    always_comb begin
        if (rst_n) begin
            mem.mem_req = mem_req_s;
            mem.mem_we  = mem_we_s;
            mem.IorD    = iord_s;
            ir_write    = ir_write_s;
            pc_write    = pc_write_s;
            ALUSrc      = alu_src_s;
            MemtoReg    = mem_to_reg_s;
            RegWrite    = reg_write_s;
            Branch      = branch_s;
            JalrSel     = jalr_sel_s;
            ALUOp       = alu_op_s;
            RWSel       = rw_sel_s;
        end else begin
            mem.mem_req = 1'b0;
            mem.mem_we  = 1'b0;
            mem.IorD    = 1'b0;
            ir_write    = 1'b0;
            pc_write    = 1'b0;
            ALUSrc      = 1'b0;
            MemtoReg    = 1'b0;
            RegWrite    = 1'b0;
            Branch      = 1'b0;
            JalrSel     = 1'b0;
            ALUOp       = 2'b00;
            RWSel       = 2'b00;
        end
    end

    assign halted = (state_r == ST_HALTED);
    assign fault  = fault_r;
    assign state  = state_r;

`ifdef MULTICYCLE_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_cnt_r;
    logic [CNT_W-1:0] instret_cnt_r;

    // Count running cycles and retired instructions; both wrap freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt_r   <= '0;
            instret_cnt_r <= '0;
        end else begin
            if (state_r != ST_HALTED) begin
                cycle_cnt_r <= cycle_cnt_r + 1'b1;
            end else begin
                cycle_cnt_r <= cycle_cnt_r;
            end
            if (pc_write_s) begin
                instret_cnt_r <= instret_cnt_r + 1'b1;
            end else begin
                instret_cnt_r <= instret_cnt_r;
            end
        end
    end

    assign cycle_cnt   = cycle_cnt_r;
    assign instret_cnt = instret_cnt_r;
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. A table of instruction records
// (opcode, memory wait pattern, expected trace and strobe summary) is driven
// one record at a time; each expected record is queued when its instruction
// is launched and popped once the instruction retires or the core halts.
// Hand-written sequences cover reset state and reset during a store.
module tb_multicycle_ctrl;

    localparam int TB_TIMEOUT = 4;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_HALT = 7'b0010111;
    localparam logic [6:0] OP_BAD  = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] Opcode;
    logic       ir_write, pc_write, ALUSrc, MemtoReg, RegWrite, Branch, JalrSel;
    logic [1:0] ALUOp, RWSel, fault;
    logic       halted;
    logic [2:0] state;
`ifdef MULTICYCLE_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_ctrl_if bus ();

    multicycle_ctrl #(.MEM_TIMEOUT(TB_TIMEOUT), .CNT_W(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Opcode      (Opcode),
        .mem         (bus.master),
        .ir_write    (ir_write),
        .pc_write    (pc_write),
        .ALUSrc      (ALUSrc),
        .MemtoReg    (MemtoReg),
        .RegWrite    (RegWrite),
        .Branch      (Branch),
        .JalrSel     (JalrSel),
        .ALUOp       (ALUOp),
        .RWSel       (RWSel),
        .halted      (halted),
        .fault       (fault),
        .state       (state)
`ifdef MULTICYCLE_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  op;
        int          fw;      // FETCH wait cycles before mem_ready
        int          mw;      // MEM wait cycles before mem_ready
        int          cycles;  // cycles until pc_write or halted (inclusive)
        logic [31:0] trace;   // 3-bit state per cycle, oldest first
        int          pcw;
        int          rw;
        int          we;
        logic [1:0]  aluop;   // ALUOp seen in EXEC
        logic        br;      // Branch at pc_write
        logic        jalr;    // JalrSel at pc_write
        logic [1:0]  rwsel;   // RWSel at RegWrite
        logic        m2r;     // MemtoReg at RegWrite
        logic        hlt;
        logic [1:0]  flt;
    } vec_t;

    vec_t tbl[14];
    vec_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(input logic [6:0] op, input int fw, input int mw,
                                input int cycles, input logic [31:0] trace,
                                input int pcw, input int rw, input int we,
                                input logic [1:0] aluop, input logic br,
                                input logic jalr, input logic [1:0] rwsel,
                                input logic m2r, input logic hlt,
                                input logic [1:0] flt);
        vec_t v;
        v.op = op; v.fw = fw; v.mw = mw; v.cycles = cycles; v.trace = trace;
        v.pcw = pcw; v.rw = rw; v.we = we; v.aluop = aluop; v.br = br;
        v.jalr = jalr; v.rwsel = rwsel; v.m2r = m2r; v.hlt = hlt; v.flt = flt;
        return v;
    endfunction

    function automatic logic [13:0] strobes();
        return {bus.mem_req, bus.mem_we, bus.IorD, ir_write, pc_write, ALUSrc,
                MemtoReg, RegWrite, Branch, JalrSel, ALUOp, RWSel};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Enter reset and release it just after a rising edge so the first
    // FETCH cycle is a full cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Launch one instruction from FETCH; called at posedge+1.
    task automatic run_instr(input int idx, input vec_t v);
        int          fcnt = 0;
        int          mcnt = 0;
        int          cyc  = 0;
        int          pcw  = 0;
        int          rw   = 0;
        int          we   = 0;
        int          viol = 0;
        logic [31:0] trace = 32'd0;
        logic [1:0]  aluop = 2'b00;
        logic [1:0]  rwsel = 2'b00;
        logic        br = 1'b0, jalr = 1'b0, m2r = 1'b0, hl = 1'b0;
        bit          done = 1'b0;
        vec_t        e;
        string       tag;

        exp_q.push_back(v);
        Opcode = v.op;
        while (!done && cyc < 40) begin
            if (state == 3'd0) begin
                bus.mem_ready = (fcnt >= v.fw);
                if (!bus.mem_ready) fcnt++;
            end else if (state == 3'd3) begin
                bus.mem_ready = (mcnt >= v.mw);
                if (!bus.mem_ready) mcnt++;
            end else begin
                // No request outstanding: mem_ready must be ignored.
                bus.mem_ready = 1'($urandom_range(0, 1));
            end
            #1;
            cyc++;
            trace = {trace[28:0], state};
            if (state == 3'd2) aluop = ALUOp;
            if (pc_write) begin pcw++; br = Branch; jalr = JalrSel; end
            if (RegWrite) begin rw++; rwsel = RWSel; m2r = MemtoReg; end
            if (bus.mem_we) we++;
            if (pc_write && ir_write) viol++;
            if (MemtoReg && !RegWrite) viol++;
            if (bus.mem_we && !bus.mem_req) viol++;
            if (bus.mem_req && (bus.IorD != (state == 3'd3))) viol++;
            if (pc_write || halted) done = 1'b1;
            hl = halted;
            @(posedge clk);
            #1;
        end
        bus.mem_ready = 1'b0;

        e = exp_q.pop_front();
        tag = $sformatf("[%0d]", idx);
        check({"finished", tag}, 32'(done), 32'd1);
        check({"cycles", tag},   32'(cyc),  32'(e.cycles));
        check({"trace", tag},    trace,     e.trace);
        check({"pc_write", tag}, 32'(pcw),  32'(e.pcw));
        check({"RegWrite", tag}, 32'(rw),   32'(e.rw));
        check({"mem_we", tag},   32'(we),   32'(e.we));
        check({"ALUOp", tag},    32'(aluop), 32'(e.aluop));
        check({"Branch", tag},   32'(br),   32'(e.br));
        check({"JalrSel", tag},  32'(jalr), 32'(e.jalr));
        check({"RWSel", tag},    32'(rwsel), 32'(e.rwsel));
        check({"MemtoReg", tag}, 32'(m2r),  32'(e.m2r));
        check({"halted", tag},   32'(hl),   32'(e.hlt));
        check({"fault", tag},    32'(fault), 32'(e.flt));
        check({"strobe_rules", tag}, 32'(viol), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int quiet;

        //           op       fw mw cyc trace                                              pcw rw we aluop br jalr rwsel m2r hlt flt
        tbl[0]  = mk(OP_R,    0, 0,  4, 32'({3'd0,3'd1,3'd2,3'd4}),                          1, 1, 0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        tbl[1]  = mk(OP_LW,   2, 1,  8, 32'({3'd0,3'd0,3'd0,3'd1,3'd2,3'd3,3'd3,3'd4}),      1, 1, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b1, 1'b0, 2'b00);
        tbl[2]  = mk(OP_SW,   0, 0,  4, 32'({3'd0,3'd1,3'd2,3'd3}),                          1, 0, 1, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        tbl[3]  = mk(OP_BR,   0, 0,  3, 32'({3'd0,3'd1,3'd2}),                               1, 0, 0, 2'b01, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        tbl[4]  = mk(OP_I,    1, 0,  5, 32'({3'd0,3'd0,3'd1,3'd2,3'd4}),                     1, 1, 0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        tbl[5]  = mk(OP_LUI,  0, 0,  4, 32'({3'd0,3'd1,3'd2,3'd4}),                          1, 1, 0, 2'b11, 1'b0, 1'b0, 2'b10, 1'b0, 1'b0, 2'b00);
        tbl[6]  = mk(OP_JAL,  0, 0,  4, 32'({3'd0,3'd1,3'd2,3'd4}),                          1, 1, 0, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 1'b0, 2'b00);
        tbl[7]  = mk(OP_JALR, 0, 0,  4, 32'({3'd0,3'd1,3'd2,3'd4}),                          1, 1, 0, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 1'b0, 2'b00);
        // mem_ready on the last permitted wait cycle completes normally
        tbl[8]  = mk(OP_R,    3, 0,  7, 32'({3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd4}),           1, 1, 0, 2'b10, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        // wait counter must clear between FETCH and MEM
        tbl[9]  = mk(OP_SW,   3, 3, 10, 32'({3'd0,3'd0,3'd0,3'd0,3'd1,3'd2,3'd3,3'd3,3'd3,3'd3}), 1, 0, 4, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 2'b00);
        tbl[10] = mk(OP_HALT, 0, 0,  3, 32'({3'd0,3'd1,3'd5}),                               0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b00);
        tbl[11] = mk(OP_BAD,  0, 0,  3, 32'({3'd0,3'd1,3'd5}),                               0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b01);
        // FETCH timeout: 4th unanswered cycle halts
        tbl[12] = mk(OP_R,   10, 0,  5, 32'({3'd0,3'd0,3'd0,3'd0,3'd5}),                     0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10);
        // MEM timeout on a load
        tbl[13] = mk(OP_LW,   0,10,  8, 32'({3'd0,3'd1,3'd2,3'd3,3'd3,3'd3,3'd3,3'd5}),      0, 0, 0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 1'b1, 2'b10);

        // Reset state: strobes low even with mem_ready pushed high.
        Opcode = OP_R;
        rst_n = 1'b0;
        bus.mem_ready = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        check("rst_strobes", 32'(strobes()), 32'd0);
        check("rst_state",   32'(state),     32'd0);
        check("rst_halted",  32'(halted),    32'd0);
        check("rst_fault",   32'(fault),     32'd0);
        bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("first_mem_req", 32'(bus.mem_req), 32'd1);
        #(-0);

        // Table-driven instruction sequence.
        for (int i = 0; i < 14; i++) begin
            run_instr(i, tbl[i]);
            if (tbl[i].hlt) begin
                quiet = 0;
                bus.mem_ready = 1'b1;
                for (int c = 0; c < 20; c++) begin
                    #1;
                    if (strobes() != 14'd0 || !halted || fault != tbl[i].flt) quiet++;
                    @(posedge clk);
                    #1;
                end
                check($sformatf("halt_quiet[%0d]", i), 32'(quiet), 32'd0);
                do_reset();
            end
        end

        // Reset while a store sits in MEM waiting for memory.
        Opcode = OP_SW;
        bus.mem_ready = 1'b1;           // FETCH completes at once
        @(posedge clk); #1;
        bus.mem_ready = 1'b0;
        @(posedge clk); #1;             // EXEC
        @(posedge clk); #1;             // MEM
        #1;
        check("sw_in_mem_state", 32'(state), 32'd3);
        check("sw_in_mem_req_we", 32'({bus.mem_req, bus.mem_we}), 32'b11);
        rst_n = 1'b0;
        #1;
        check("abort_strobes", 32'(strobes()), 32'd0);
        check("abort_state",   32'(state),     32'd0);
        quiet = 0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #2;
            if (pc_write || RegWrite || bus.mem_req) quiet++;
        end
        check("abort_quiet", 32'(quiet), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check("release_fetch", 32'({state, bus.mem_req, bus.IorD, bus.mem_we}),
              32'({3'd0, 1'b1, 1'b0, 1'b0}));
`ifdef MULTICYCLE_PERF_CNT_EN
        check("cycle_cnt_rst",   cycle_cnt,   32'd0);
        check("instret_cnt_rst", instret_cnt, 32'd0);
`endif
        #(-0);
        // The core must run normally after the aborted store.
        run_instr(100, tbl[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle sequencer for the RV32 subset core; replaces single-cycle main decode when instruction and data share one memory port.
- Walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives the existing datapath strobes plus PC/IR write enables and a req/ready memory handshake.
- Sits between the IR opcode field and the datapath muxes, register file and memory interface.

Parameters:
- MEM_TIMEOUT, 15: max wait cycles on an unanswered mem_req before fault; 0 disables the timeout.
- CNT_W, 32: width of the performance counters. Used only with PERF_CNT_EN.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  IR[6:0]; stable from the cycle after ir_write
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory access request
- mem_we  out  1  write qualifier for mem_req (SW)
- IorD  out  1  memory address select: 0 = PC, 1 = ALU result
- ir_write  out  1  load IR from memory read data
- pc_write  out  1  commit next PC (PC+4, branch/jal target, or jalr target per Branch/JalrSel)
- ALUSrc, MemtoReg, RegWrite, Branch, JalrSel  out  1 each  same meaning as the single-cycle control
- ALUOp  out  2  00 add, 01 branch compare, 10 R/I-type funct decode, 11 JAL/LUI
- RWSel  out  2  01 = PC+4, 10 = LUI immediate, 00 = ALU/mem
- halted  out  1  core stopped; sticky
- fault  out  2  00 none, 01 illegal opcode, 10 memory timeout
- state  out  3  current state, for debug

Behaviour:
- One clock. Reset is asynchronous and active-low.
- Reset: state = FETCH, wait counter = 0, halted = 0, fault = 00.
- While rst_n = 0, every strobe output is 0; mem_req rises in the first cycle after deassertion.
- Reset mid-operation aborts the instruction immediately. No pc_write or RegWrite occurs.
- Opcodes:
  - R 0110011, I 0010011, LW 0000011, SW 0100011
  - BR 1100011, LUI 0110111, JAL 1101111, JALR 1100111
  - HALT 0010111
  - Anything else is illegal.
- State encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALTED 5. Codes 6–7 go to HALTED with fault = 01.
- Outputs are decoded combinationally from state and Opcode. The state register is the only sequential control.
- FETCH:
  - mem_req = 1, IorD = 0, mem_we = 0.
  - ir_write = mem_ready.
  - On mem_ready go to DECODE; otherwise stay.
- DECODE:
  - No strobes.
  - HALT → HALTED, fault 00.
  - Illegal opcode → HALTED, fault 01.
  - Otherwise → EXEC.
- EXEC:
  - ALUSrc/ALUOp/Branch/JalrSel set per opcode, as in single-cycle decode.
  - LW/SW → MEM.
  - BR → pc_write = 1 with Branch = 1, then → FETCH.
  - R/I/LUI/JAL/JALR → WB.
- MEM:
  - mem_req = 1, IorD = 1, mem_we = (SW). EXEC ALU controls held.
  - On mem_ready: LW → WB; SW → pc_write = 1, then → FETCH.
- WB:
  - RegWrite = 1, pc_write = 1; MemtoReg and RWSel per opcode.
  - Branch/JalrSel held for JAL/JALR target selection.
  - Then → FETCH.
- Latency with zero-wait memory: BR 3, R/I/LUI/JAL/JALR 4, SW 4, LW 5 cycles. Each memory wait cycle adds 1.
- mem_ready in the same cycle as mem_req is a zero-wait completion. mem_ready while mem_req = 0 is ignored.
- Timeout:
  - The wait counter increments each FETCH/MEM cycle with mem_req = 1 and mem_ready = 0. It clears on completion.
  - If the counter reaches MEM_TIMEOUT (MEM_TIMEOUT > 0) → HALTED, fault 10.
  - mem_ready arriving in that same cycle wins: normal completion, no fault.
- HALTED: halted = 1, all strobes 0. The only exit is reset.
- At most one pc_write per instruction. Never pc_write and ir_write in the same cycle.

Optional Feature:
- Macro: MULTICYCLE_PERF_CNT_EN.
- When defined, adds outputs cycle_cnt and instret_cnt (CNT_W bits each, reset 0).
  - cycle_cnt increments every non-HALTED cycle.
  - instret_cnt increments on each pc_write.
  - Both wrap modulo 2^CNT_W.
- When undefined, the ports and counters do not exist.

Test Plan:
- R-type 0110011, mem_ready always 1 → states 0,1,2,4; one RegWrite + pc_write pulse in cycle 4; ALUOp = 10.
- LW with 2 wait cycles in FETCH and 1 in MEM → 8 cycles total; mem_we = 0; MemtoReg = RegWrite = 1 only in WB.
- SW then BR, zero-wait → SW 4 cycles with mem_we = 1 in MEM and no RegWrite; BR 3 cycles with pc_write + Branch in EXEC, ALUOp = 01.
- HALT 0010111 → halted = 1 after DECODE, fault = 00, all strobes 0 for 20 cycles. Opcode 1111111 → fault = 01.
- MEM_TIMEOUT = 4, mem_ready held 0 in FETCH → halted with fault = 10 on the 4th wait cycle. Repeat with mem_ready on the 4th wait cycle → enters DECODE, no fault.
- Assert rst_n = 0 during MEM of an SW → mem_req/mem_we drop asynchronously with no pc_write. After release, FETCH with mem_req = 1 in the first cycle. With MULTICYCLE_PERF_CNT_EN, both counters read 0.
